// File: rtl/sr_ff.sv
// Bank of WIDTH independent, clocked SR flip-flops with a selectable S=R=1 policy.
// Q, Qn and err all come straight from flops, and reset is synchronous.
module sr_ff #(
  parameter int WIDTH        = 1,
  parameter int INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] err
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_ff: WIDTH must be in 1..64");
  end

  if (INVALID_MODE < 0 || INVALID_MODE > 3) begin : g_bad_mode
    $error("sr_ff: INVALID_MODE must be in 0..3");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic q_reg;
    logic qn_reg;
    logic err_reg;
    logic q_next;
    logic both_next;

    always_comb begin
      both_next = S[gi] & R[gi];
      q_next    = q_reg;
      if (both_next) begin
        case (INVALID_MODE)
          1:       q_next = 1'b0;
          2:       q_next = 1'b1;
          3:       q_next = ~q_reg;
          default: q_next = q_reg;
        endcase
      end else if (S[gi]) begin
        q_next = 1'b1;
      end else if (R[gi]) begin
        q_next = 1'b0;
      end
    end

    // Qn is a separate flop loaded with the complement of the same next value,
    // so it tracks Q on every edge without any gate between the flop and the pin.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg   <= 1'b0;
        qn_reg  <= 1'b1;
        err_reg <= 1'b0;
      end else begin
        q_reg   <= q_next;
        qn_reg  <= ~q_next;
        err_reg <= both_next;
      end
    end

    assign Q[gi]   = q_reg;
    assign Qn[gi]  = qn_reg;
    assign err[gi] = err_reg;
  end

endmodule

// File: tb/tb_sr_ff.sv
// Scoreboard bench for sr_ff: four 1-bit instances (one per S=R=1 policy) and one
// 4-bit mode-0 instance share the stimulus, and a monitor checks each edge.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s1 = 1'b0;
  logic       r1 = 1'b0;
  logic [3:0] sv = 4'd0;
  logic [3:0] rv = 4'd0;

  logic [3:0] q_m, qn_m, e_m;
  logic [3:0] q_v, qn_v, e_v;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    sr_ff #(.WIDTH(1), .INVALID_MODE(gi)) u_dut (
      .clk (clk),
      .rst (rst),
      .S   (s1),
      .R   (r1),
      .Q   (q_m[gi]),
      .Qn  (qn_m[gi]),
      .err (e_m[gi])
    );
  end

  sr_ff #(.WIDTH(4), .INVALID_MODE(0)) u_vec (
    .clk (clk),
    .rst (rst),
    .S   (sv),
    .R   (rv),
    .Q   (q_v),
    .Qn  (qn_v),
    .err (e_v)
  );

  typedef struct packed {
    logic [3:0] q1;
    logic       err1;
    logic [3:0] qv;
    logic [3:0] errv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int checks = 0;
  int failures = 0;

  logic [3:0] mq;
  logic [3:0] mv;

  // Reference rule for one bit, straight from the S/R truth table and the policy list.
  function automatic logic ref_next(input logic q, input logic s, input logic r, input int mode);
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (!s && !r) return q;
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    if (mode == 3) return !q;
    return q;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  task automatic step(input logic rs, input logic s, input logic r,
                      input logic [3:0] svv, input logic [3:0] rvv, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    // Inverted values first: anything seen between edges must not matter.
    s1 = ~s; r1 = ~r; sv = ~svv; rv = ~rvv;
    #2;
    rst = rs; s1 = s; r1 = r; sv = svv; rv = rvv;
    for (int m = 0; m < 4; m++)
      mq[m] = rs ? 1'b0 : ref_next(mq[m], s, r, m);
    for (int b = 0; b < 4; b++)
      mv[b] = rs ? 1'b0 : ref_next(mv[b], svv[b], rvv[b], 0);
    e.q1   = mq;
    e.err1 = !rs && s && r;
    e.qv   = mv;
    e.errv = rs ? 4'd0 : (svv & rvv);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        for (int m = 0; m < 4; m++) begin
          chk($sformatf("%s m%0d Q", nm, m), {3'd0, q_m[m]}, {3'd0, e.q1[m]});
          chk($sformatf("%s m%0d Qn", nm, m), {3'd0, qn_m[m]}, {3'd0, ~e.q1[m]});
          chk($sformatf("%s m%0d err", nm, m), {3'd0, e_m[m]}, {3'd0, e.err1});
        end
        chk($sformatf("%s vec Q", nm), q_v, e.qv);
        chk($sformatf("%s vec Qn", nm), qn_v, ~e.qv);
        chk($sformatf("%s vec err", nm), e_v, e.errv);
        $display("txn %-10s rst=%b S=%b R=%b Sv=%b Rv=%b -> Q=%b err=%b Qv=%b errv=%b",
                 nm, rst, s1, r1, sv, rv, q_m, e_m, q_v, e_v);
      end
    end
  end

  initial begin
    logic rs, s, r;
    logic [3:0] a, b;
    mq = 'x;
    mv = 'x;

    step(1, 1, 0, 4'hF, 4'h0, "reset");
    step(0, 1, 0, 4'h0, 4'h0, "set");
    repeat (3) step(0, 0, 0, 4'h0, 4'h0, "hold");
    step(0, 0, 1, 4'h0, 4'h0, "clear");

    step(0, 1, 0, 4'h0, 4'h0, "set");
    repeat (3) step(0, 1, 1, 4'h0, 4'h0, "both");
    step(0, 0, 0, 4'h0, 4'h0, "release");

    step(0, 1, 0, 4'h0, 4'h0, "set");
    step(1, 1, 0, 4'h0, 4'h0, "midreset");
    step(0, 1, 0, 4'h0, 4'h0, "resume");

    step(1, 0, 0, 4'h0, 4'h0, "vreset");
    step(0, 0, 0, 4'b1010, 4'b0110, "vector");

    for (int i = 0; i < 40; i++) begin
      rs = ($urandom_range(0, 15) == 0);
      s  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      step(rs, s, r, a, b, "random");
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff.md
SR_FF -- requirements
Module: sr_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent SR flip-flop bits; legal range 1..64.
REQ-002 Parameter INVALID_MODE, default 0: S=R=1 policy.
- 0 = hold.
- 1 = reset-dominant.
- 2 = set-dominant.
- 3 = toggle.
REQ-003 Port list, in this order:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- S  input  WIDTH  per-bit set request.
- R  input  WIDTH  per-bit reset request.
- Q  output  WIDTH  registered state.
- Qn  output  WIDTH  registered complement of Q.
- err  output  WIDTH  per-bit flag: S=R=1 sampled at the last edge.
REQ-004 All outputs SHALL be driven directly from flops; no combinational path from S, R or rst to any output.

Function
REQ-005 All state SHALL update only on the rising edge of clk; latency from S/R sampling to Q/Qn is exactly one cycle.
REQ-006 Each bit i SHALL be independent; S[i]/R[i] affect only Q[i], Qn[i] and err[i].
REQ-007 Per-bit next state when rst=0:
- S=0, R=0: hold.
- S=1, R=0: Q=1.
- S=0, R=1: Q=0.
REQ-008 S=1, R=1 SHALL apply INVALID_MODE:
- 0: hold.
- 1: Q=0.
- 2: Q=1.
- 3: Q=~Q.
REQ-009 Q and Qn SHALL never output X or Z for any input combination.
REQ-010 Qn SHALL equal ~Q on every cycle, including the reset cycle and the S=R=1 cycle; both come from the same edge.
REQ-011 err[i] SHALL be 1 for exactly the cycle after an edge where S[i]=R[i]=1 was sampled, else 0.
- Consecutive S=R=1 cycles keep err high.
- err SHALL NOT alter Q.
REQ-012 S or R that are X/Z at an edge are out of contract; the bench SHALL drive only 0/1.
REQ-013 Inputs changing between edges SHALL have no effect until the next rising edge.
REQ-014 An illegal INVALID_MODE (>3) or WIDTH (<1 or >64) SHALL be rejected at elaboration with an error.

Reset
REQ-015 When rst=1 at a rising edge: Q=0, Qn=all ones, err=0 on every bit, regardless of S/R.
REQ-016 rst SHALL have priority over S, R and INVALID_MODE.
REQ-017 Asserting rst mid-operation SHALL take effect at the next edge only; no asynchronous clearing.
REQ-018 Power-up state before the first reset edge is undefined; after one rst edge all outputs are defined.
REQ-019 On the first edge with rst=0, normal S/R evaluation applies with no extra idle cycle.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (WIDTH=1 unless stated):
- Reset: rst=1, S=1, R=0 for one edge -> Q=0, Qn=1, err=0.
- Set/hold/reset: after reset, S=1,R=0 -> Q=1,Qn=0; then S=0,R=0 for 3 edges -> Q stays 1; then S=0,R=1 -> Q=0,Qn=1.
- Invalid, mode 0: Q=1, then S=R=1 -> Q=1, err=1 next cycle; then S=R=0 -> err=0.
- Invalid, modes 1/2/3 from Q=1 with S=R=1: mode 1 -> Q=0; mode 2 -> Q=1; mode 3 -> Q alternates 0,1,0 over 3 edges.
- Mid-operation reset: Q=1 with S=1 held, rst pulsed for one edge -> Q=0; next edge with rst=0, S=1 -> Q=1.
- Vector (WIDTH=4): S=4'b1010, R=4'b0110 from reset -> Q=4'b1000, Qn=4'b0111, err=4'b0010 (mode 0).
REQ-021 The bench SHALL also run 20+ random S/R cycles against a reference model, checking Qn==~Q every cycle.
